// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and helpers for the stream round-robin arbiter.
// Holds the packet-lock FSM state encoding and the source-index width function.
package stream_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Index width for NUM_IN inputs; never below one bit so m_src always exists.
  function automatic int clog2_num(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_grant.sv
// Combinational rotate-priority picker: the first requester at or after ptr
// (wrapping from NUM_IN-1 to 0) is granted, as a one-hot vector and an index.
module rr_grant
  import stream_rr_arbiter_pkg::*;
#(
  parameter int NUM_IN = 4,
  localparam int IDX_W = clog2_num(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_any
);

  logic [IDX_W:0]      pos_s;
  logic [NUM_IN-1:0]   grant_s;
  logic [IDX_W-1:0]    idx_s;
  logic                found_s;

  // Walk the rotated priority order and latch onto the first active request.
  always_comb begin
    grant_s = '0;
    idx_s   = '0;
    found_s = 1'b0;
    pos_s   = '0;
    for (int off = 0; off < NUM_IN; off++) begin
      pos_s = {1'b0, ptr} + (IDX_W+1)'(off);
      if (pos_s >= (IDX_W+1)'(NUM_IN)) begin
        pos_s = pos_s - (IDX_W+1)'(NUM_IN);
      end else begin
        pos_s = pos_s;
      end
      if (!found_s && req[pos_s[IDX_W-1:0]]) begin
        found_s                  = 1'b1;
        grant_s[pos_s[IDX_W-1:0]] = 1'b1;
        idx_s                    = pos_s[IDX_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  assign grant     = grant_s;
  assign grant_idx = idx_s;
  assign grant_any = found_s;

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging NUM_IN valid/ready streams into one registered output.
// Define STREAM_RR_ARBITER_PKT_LOCK_EN to hold the grant for a whole packet (s_last framed).
module stream_rr_arbiter
  import stream_rr_arbiter_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 8,
  localparam int IDX_W     = clog2_num(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            s_valid,
  output logic [NUM_IN-1:0]            s_ready,
  input  logic [NUM_IN*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_IN-1:0]            s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_last,
  output logic [IDX_W-1:0]             m_src
);

  logic                  m_valid_r;
  logic [DATA_WIDTH-1:0] m_data_r;
  logic                  m_last_r;
  logic [IDX_W-1:0]      m_src_r;
  logic [IDX_W-1:0]      ptr_r;
  logic [IDX_W-1:0]      ptr_nxt_s;
  logic [NUM_IN-1:0]     req_s;
  logic [NUM_IN-1:0]     grant_s;
  logic [IDX_W-1:0]      grant_idx_s;
  logic                  grant_any_s;
  logic                  load_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  sel_last_s;
  logic [IDX_W-1:0]      idx_inc_s;

`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
  arb_state_t            state_r;
  arb_state_t            state_nxt_s;
  logic [IDX_W-1:0]      lock_idx_r;
  logic [IDX_W-1:0]      lock_idx_nxt_s;
  logic [NUM_IN-1:0]     lock_mask_s;

  // While locked only the locked input may compete, so others see no s_ready.
  always_comb begin
    lock_mask_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      lock_mask_s[i] = (lock_idx_r == IDX_W'(i));
    end
    if (state_r == ST_LOCKED) begin
      req_s = s_valid & lock_mask_s;
    end else begin
      req_s = s_valid;
    end
  end
`else
  assign req_s = s_valid;
`endif

  rr_grant #(.NUM_IN(NUM_IN)) u_rr_grant (
    .req       (req_s),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  assign load_s  = grant_any_s && (!m_valid_r || m_ready) && !rst;
  assign s_ready = load_s ? grant_s : {NUM_IN{1'b0}};

  // One-hot AND-OR mux of the granted payload and end-of-packet flag.
  always_comb begin
    sel_data_s = '0;
    sel_last_s = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      sel_data_s = sel_data_s | ({DATA_WIDTH{grant_s[i]}} & s_data[i*DATA_WIDTH +: DATA_WIDTH]);
      sel_last_s = sel_last_s | (grant_s[i] & s_last[i]);
    end
  end

  assign idx_inc_s = (grant_idx_s == IDX_W'(NUM_IN-1)) ? IDX_W'(0) : grant_idx_s + IDX_W'(1);

  // Next priority pointer and, with packet lock, the lock FSM.
  always_comb begin
    ptr_nxt_s = ptr_r;
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
    state_nxt_s    = state_r;
    lock_idx_nxt_s = lock_idx_r;
    if (load_s && sel_last_s) begin
      ptr_nxt_s = idx_inc_s;
    end else begin
      ptr_nxt_s = ptr_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (load_s && !sel_last_s) begin
          state_nxt_s    = ST_LOCKED;
          lock_idx_nxt_s = grant_idx_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (load_s && sel_last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_LOCKED;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
`else
    if (load_s) begin
      ptr_nxt_s = idx_inc_s;
    end else begin
      ptr_nxt_s = ptr_r;
    end
`endif
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
      state_r    <= ST_IDLE;
      lock_idx_r <= '0;
`endif
    end else begin
      ptr_r <= ptr_nxt_s;
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
      state_r    <= state_nxt_s;
      lock_idx_r <= lock_idx_nxt_s;
`endif
    end
  end

  // Output register stage; payload is held when the beat drains without refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_r <= 1'b0;
      m_data_r  <= '0;
      m_last_r  <= 1'b0;
      m_src_r   <= '0;
    end else if (load_s) begin
      m_valid_r <= 1'b1;
      m_data_r  <= sel_data_s;
      m_last_r  <= sel_last_s;
      m_src_r   <= grant_idx_s;
    end else if (m_ready) begin
      m_valid_r <= 1'b0;
    end
  end

  assign m_valid = m_valid_r;
  assign m_data  = m_data_r;
  assign m_last  = m_last_r;
  assign m_src   = m_src_r;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a queue-free model.
module tb_stream_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk;
  logic            rst;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_ready;
  logic [N*DW-1:0] s_data;
  logic [N-1:0]    s_last;
  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_data;
  logic            m_last;
  logic [1:0]      m_src;

  int checks = 0;
  int errors = 0;

  stream_rr_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_src   (m_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: priority order, lock and output-register contents in plain ints.
  bit            mk = 1'b0;
  bit            mv = 1'b0;
  bit            ml = 1'b0;
  logic [DW-1:0] md = '0;
  int            ms = 0;
  int            ptr = 0;
  bit            locked = 1'b0;
  int            lidx = 0;

  always begin
    @(negedge clk);
    begin : model_step
      int win;
      bit acc;
      logic [N-1:0] er;
      win = -1;
      for (int off = 0; off < N; off++) begin
        int k;
        k = (ptr + off) % N;
        if (win < 0 && s_valid[k] && (!locked || k == lidx)) win = k;
      end
      acc = mk && !rst && (win >= 0) && (!mv || m_ready);
      er = '0;
      if (acc) er[win] = 1'b1;
      if (mk) begin
        chk("model_s_ready", 32'(s_ready), 32'(er));
        chk("model_m_valid", 32'(m_valid), 32'(mv));
        if (mv) begin
          chk("model_m_data", 32'(m_data), 32'(md));
          chk("model_m_last", 32'(m_last), 32'(ml));
          chk("model_m_src", 32'(m_src), 32'(ms));
        end
      end
      if (rst) begin
        mk = 1'b1; mv = 1'b0; ml = 1'b0; md = '0; ms = 0;
        ptr = 0; locked = 1'b0; lidx = 0;
      end else if (mk) begin
        if (acc) begin
          mv = 1'b1;
          md = s_data[win*DW +: DW];
          ml = s_last[win];
          ms = win;
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
          if (s_last[win]) begin
            ptr = (win + 1) % N;
            locked = 1'b0;
          end else begin
            locked = 1'b1;
            lidx = win;
          end
`else
          ptr = (win + 1) % N;
`endif
        end else if (mv && m_ready) begin
          mv = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_in(input int i, input bit v, input logic [DW-1:0] d, input bit l);
    s_valid[i]          = v;
    s_data[i*DW +: DW]  = d;
    s_last[i]           = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = '0;
    s_last = '0;
    m_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s_valid = '0;
    s_last = '0;
    s_data = '0;
    m_ready = 1'b0;

    // Reset state
    sample();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_src", 32'(m_src), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);

    // All inputs valid, single-beat packets: sources rotate 0,1,2,3,0
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) set_in(i, 1'b1, 8'(8'h10 + i), 1'b1);
    for (int c = 0; c < 6; c++) begin
      sample();
      chk("rr_s_ready", 32'(s_ready), 32'(1 << (c % N)));
      if (c >= 1) begin
        chk("rr_m_valid", 32'(m_valid), 32'd1);
        chk("rr_m_src", 32'(m_src), 32'((c - 1) % N));
        chk("rr_m_data", 32'(m_data), 32'(8'h10 + ((c - 1) % N)));
      end
      tick();
    end
    s_valid = '0;

    // Backpressure holds the registered beat for 5 cycles
    do_reset();
    set_in(2, 1'b1, 8'hA5, 1'b1);
    sample();
    chk("bp_first_ready", 32'(s_ready), 32'h4);
    tick();
    set_in(2, 1'b1, 8'h5A, 1'b1);
    for (int c = 0; c < 5; c++) begin
      sample();
      chk("bp_m_valid", 32'(m_valid), 32'd1);
      chk("bp_m_data", 32'(m_data), 32'hA5);
      chk("bp_m_src", 32'(m_src), 32'd2);
      chk("bp_s_ready", 32'(s_ready), 32'd0);
      tick();
    end
    m_ready = 1'b1;
    sample();
    chk("bp_release_ready", 32'(s_ready), 32'h4);
    tick();
    s_valid = '0;
    sample();
    chk("bp_second_beat", 32'(m_data), 32'h5A);
    chk("bp_second_valid", 32'(m_valid), 32'd1);
    tick();
    sample();
    chk("bp_drained", 32'(m_valid), 32'd0);

    // Reset in the middle of a packet
    do_reset();
    m_ready = 1'b1;
    set_in(1, 1'b1, 8'h31, 1'b0);
    sample();
    chk("mid_rst_first", 32'(s_ready), 32'h2);
    tick();
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_in(i, 1'b1, 8'(8'h40 + i), 1'b1);
    sample();
    chk("mid_rst_ready", 32'(s_ready), 32'd0);
    tick();
    sample();
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_ready2", 32'(s_ready), 32'd0);
    tick();
    rst = 1'b0;
    sample();
    chk("post_rst_winner", 32'(s_ready), 32'h1);
    tick();
    sample();
    chk("post_rst_src", 32'(m_src), 32'd0);
    chk("post_rst_data", 32'(m_data), 32'h40);
    tick();
    s_valid = '0;

`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
    // 3-beat packet from input 1 is not interleaved with input 2
    do_reset();
    m_ready = 1'b1;
    set_in(1, 1'b1, 8'hA1, 1'b0);
    set_in(2, 1'b1, 8'hB0, 1'b1);
    sample(); chk("lock_r0", 32'(s_ready), 32'h2); tick();
    set_in(1, 1'b1, 8'hA2, 1'b0);
    sample(); chk("lock_r1", 32'(s_ready), 32'h2); chk("lock_d1", 32'(m_data), 32'hA1); tick();
    set_in(1, 1'b1, 8'hA3, 1'b1);
    sample(); chk("lock_r2", 32'(s_ready), 32'h2); chk("lock_d2", 32'(m_data), 32'hA2); tick();
    set_in(1, 1'b0, 8'h00, 1'b0);
    sample(); chk("lock_r3", 32'(s_ready), 32'h4); chk("lock_d3", 32'(m_data), 32'hA3);
    chk("lock_l3", 32'(m_last), 32'd1); tick();
    sample(); chk("lock_d4", 32'(m_data), 32'hB0); chk("lock_s4", 32'(m_src), 32'd2); tick();
    s_valid = '0;

    // Locked input 0 bubbles for 2 cycles; input 3 must wait
    do_reset();
    m_ready = 1'b1;
    set_in(0, 1'b1, 8'h01, 1'b0);
    set_in(3, 1'b1, 8'h31, 1'b1);
    sample(); chk("bub_r0", 32'(s_ready), 32'h1); tick();
    set_in(0, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 2; c++) begin
      sample(); chk("bub_hold", 32'(s_ready), 32'd0); tick();
    end
    set_in(0, 1'b1, 8'h02, 1'b1);
    sample(); chk("bub_last", 32'(s_ready), 32'h1); tick();
    set_in(0, 1'b0, 8'h00, 1'b0);
    sample(); chk("bub_other", 32'(s_ready), 32'h8); tick();
    s_valid = '0;
`else
    // Without packet lock, 2-beat packets from inputs 0 and 1 interleave
    do_reset();
    m_ready = 1'b1;
    set_in(0, 1'b1, 8'h01, 1'b0);
    set_in(1, 1'b1, 8'h11, 1'b0);
    sample(); chk("il_r0", 32'(s_ready), 32'h1); tick();
    set_in(0, 1'b1, 8'h02, 1'b1);
    sample(); chk("il_r1", 32'(s_ready), 32'h2);
    chk("il_d0", 32'(m_data), 32'h01); chk("il_l0", 32'(m_last), 32'd0); tick();
    set_in(1, 1'b1, 8'h12, 1'b1);
    sample(); chk("il_r2", 32'(s_ready), 32'h1);
    chk("il_d1", 32'(m_data), 32'h11); chk("il_s1", 32'(m_src), 32'd1); tick();
    set_in(0, 1'b0, 8'h00, 1'b0);
    sample(); chk("il_r3", 32'(s_ready), 32'h2);
    chk("il_d2", 32'(m_data), 32'h02); chk("il_l2", 32'(m_last), 32'd1); tick();
    set_in(1, 1'b0, 8'h00, 1'b0);
    sample(); chk("il_d3", 32'(m_data), 32'h12);
    chk("il_l3", 32'(m_last), 32'd1); chk("il_s3", 32'(m_src), 32'd1); tick();
`endif

    // Randomized traffic, checked every cycle by the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 127) == 0);
      for (int i = 0; i < N; i++) begin
        set_in(i, ($urandom_range(0, 2) != 0), 8'($urandom), ($urandom_range(0, 2) == 0));
      end
      m_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;
    s_valid = '0;
    m_ready = 1'b1;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 Parameter NUM_IN, default 4, number of requesting input streams (2..16).
REQ-002 Parameter DATA_WIDTH, default 8, payload width per beat.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_valid  input  NUM_IN  per-input beat valid.
REQ-006 s_ready  output  NUM_IN  per-input beat accept.
REQ-007 s_data  input  NUM_IN*DATA_WIDTH  payloads; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 s_last  input  NUM_IN  per-input end-of-packet marker.
REQ-009 m_valid  output  1  output beat valid.
REQ-010 m_ready  input  1  downstream accept.
REQ-011 m_data  output  DATA_WIDTH  output payload.
REQ-012 m_last  output  1  end-of-packet of the output beat.
REQ-013 m_src  output  clog2(NUM_IN)  index of the input that supplied the output beat.

Function
REQ-014 Transfer on any port occurs when valid and ready are both high at a rising edge; the block never drops or duplicates a beat.
REQ-015 m_valid, m_data, m_last and m_src come from a single output register stage; input-to-output latency is exactly 1 cycle.
REQ-016 The output register loads when a grant exists and (!m_valid || m_ready), so full throughput (one beat per cycle) is sustained under continuous m_ready.
REQ-017 s_ready is one-hot or zero; s_ready[i] = grant[i] && (!m_valid || m_ready); s_ready is never asserted for an input whose s_valid is low.
REQ-018 Grant selection is round-robin: priority starts at index ptr and wraps from NUM_IN-1 to 0; the lowest rotated index with s_valid high wins.
REQ-019 After an accepted beat from input g that ends arbitration (see REQ-021/REQ-026), ptr becomes g+1 modulo NUM_IN; otherwise ptr holds.
REQ-020 FSM states: IDLE (no lock, arbitrate each cycle) and LOCKED (grant fixed to locked index).
REQ-021 IDLE -> LOCKED on an accepted beat with s_last low; LOCKED -> IDLE on an accepted beat from the locked input with s_last high; a single-beat packet (s_last high on the first beat) stays in IDLE.
REQ-022 In LOCKED, other inputs receive no s_ready, even while the locked input has s_valid low (bubbles allowed, no interleave).
REQ-023 Backpressure (m_valid high, m_ready low) holds output registers, FSM and ptr unchanged.
REQ-024 No s_valid asserted: grant empty, all s_ready low, ptr unchanged; m_valid drops after the pending beat is accepted.

Reset
REQ-025 While rst is high: m_valid=0, m_data=0, m_last=0, m_src=0, s_ready all 0, FSM=IDLE, ptr=0; reset mid-packet discards the lock and any registered beat without completing the transfer.

Configuration
REQ-026 Macro STREAM_RR_ARBITER_PKT_LOCK_EN: when defined, REQ-020 to REQ-022 apply and ptr advances only on last beats; when undefined, no FSM exists, arbitration happens every beat, ptr advances on every accepted beat, and s_last passes through to m_last unchanged.

Structure
REQ-027 A shared package holds the FSM state enum (IDLE, LOCKED) and the function returning clog2 of NUM_IN.
REQ-028 Sub-module rr_grant (combinational rotate-priority picker: inputs req and ptr, outputs one-hot grant and its index) is instantiated once.

Verification
REQ-029 NUM_IN=4, all s_valid high, single-beat packets, m_ready high -> m_src sequence 0,1,2,3,0 on consecutive cycles, m_valid continuously high.
REQ-030 Input 1 sends a 3-beat packet (A1,A2,A3) while input 2 is continuously valid, lock enabled -> m_data A1,A2,A3 then input 2 beat, with no input-2 beat interleaved.
REQ-031 m_ready low for 5 cycles with a beat held in the output register -> m_data and m_src stable, s_ready all 0, no beat lost after m_ready rises.
REQ-032 Locked input 0 drops s_valid for 2 cycles mid-packet while input 3 is valid -> s_ready[3] stays 0 until input 0's last beat is accepted.
REQ-033 rst asserted mid-packet -> next cycle m_valid=0, s_ready=0, ptr=0; after rst is released, input 0 wins first when all inputs are valid.
REQ-034 Build without STREAM_RR_ARBITER_PKT_LOCK_EN, inputs 0 and 1 each sending 2-beat packets -> beats interleave 0,1,0,1 and m_last mirrors the s_last of each beat.
